// File: rtl/msi_interrupt_ctrl_if.sv
// PCIe endpoint configuration interrupt interface (Virtex-5 cfg_interrupt_* group).
// The controller is the master; the endpoint is the slave.
interface msi_interrupt_ctrl_if;
    logic       cfg_interrupt_n;
    logic       cfg_interrupt_rdy_n;
    logic       cfg_interrupt_assert_n;
    logic       cfg_interrupt_msienable;
    logic [7:0] cfg_interrupt_di;

    modport master (
        output cfg_interrupt_n,
        output cfg_interrupt_assert_n,
        output cfg_interrupt_di,
        input  cfg_interrupt_rdy_n,
        input  cfg_interrupt_msienable
    );

    modport slave (
        input  cfg_interrupt_n,
        input  cfg_interrupt_assert_n,
        input  cfg_interrupt_di,
        output cfg_interrupt_rdy_n,
        output cfg_interrupt_msienable
    );
endinterface

// File: rtl/msi_interrupt_ctrl.sv
// MSI interrupt controller: turns level requests from the Rx/Tx interrupt generators
// into single MSI handshakes on the endpoint cfg interface, with a programmable holdoff.
module msi_interrupt_ctrl #(
    parameter int unsigned HOLDOFF_W  = 16,
    parameter logic [7:0]  MSI_VECTOR = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_send_interrupt,
    input  logic                 tx_send_interrupt,
    input  logic                 interrupts_enabled,
    input  logic [HOLDOFF_W-1:0] holdoff_cycles,
    msi_interrupt_ctrl_if.master cfg,
    output logic [1:0]           irq_source,
    output logic [31:0]          interrupt_count
);
    localparam int unsigned COUNT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t               state;
    logic [HOLDOFF_W-1:0] holdoff_cnt;
    logic                 launch_c;

    assign launch_c = (rx_send_interrupt | tx_send_interrupt) & interrupts_enabled
                    & cfg.cfg_interrupt_msienable;

    // Once launched, a request is held until the endpoint acknowledges it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            holdoff_cnt                <= '0;
            irq_source                 <= 2'b00;
            interrupt_count            <= '0;
            cfg.cfg_interrupt_n        <= 1'b1;
            cfg.cfg_interrupt_assert_n <= 1'b1;
            cfg.cfg_interrupt_di       <= MSI_VECTOR;
        end else begin
            cfg.cfg_interrupt_assert_n <= 1'b1;
            cfg.cfg_interrupt_di       <= MSI_VECTOR;
            case (state)
                IDLE: begin
                    if (launch_c) begin
                        cfg.cfg_interrupt_n <= 1'b0;
                        irq_source          <= {tx_send_interrupt, rx_send_interrupt};
                        state               <= REQ;
                    end
                end
                REQ: begin
                    if (!cfg.cfg_interrupt_rdy_n) begin
                        cfg.cfg_interrupt_n <= 1'b1;
                        interrupt_count     <= interrupt_count + COUNT_W'(1);
                        holdoff_cnt         <= holdoff_cycles;
                        state               <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    // Counting down from holdoff_cycles plus the IDLE launch cycle
                    // yields a gap of holdoff_cycles+2 between requests.
                    if (holdoff_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        holdoff_cnt <= holdoff_cnt - HOLDOFF_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/msi_interrupt_ctrl.md
Name: msi_interrupt_ctrl

Overview:
- Sits directly downstream of the Rx and Tx interrupt generators and drives the Virtex-5 PCIe endpoint configuration interrupt interface.
- Turns level-style interrupt requests (send_interrupt from Rx and Tx) into single MSI transactions using the cfg_interrupt_n / cfg_interrupt_rdy_n handshake.
- Applies a driver-programmable holdoff (moderation) window between consecutive MSIs, and keeps a source snapshot and a sent-interrupt count for the driver.

Parameters:
- HOLDOFF_W, 16, width of the holdoff_cycles input and the internal holdoff counter.
- MSI_VECTOR, 8'h00, value driven on cfg_interrupt_di for every request.

Ports:
- clk  input  1  core clock; same domain as the interrupt generators and the PCIe cfg interface.
- reset  input  1  asynchronous, active-high reset.
- rx_send_interrupt  input  1  level request from the Rx interrupt generator.
- tx_send_interrupt  input  1  level request from the Tx interrupt generator.
- interrupts_enabled  input  1  driver register bit; 0 blocks new requests.
- holdoff_cycles  input  HOLDOFF_W  minimum quiet period after each MSI; driver register, sampled at handshake completion.
- cfg_interrupt_msienable  input  1  from the endpoint; MSI is enabled by the host.
- cfg_interrupt_rdy_n  input  1  from the endpoint; active-low acknowledge.
- cfg_interrupt_n  output  1  to the endpoint; active-low request.
- cfg_interrupt_assert_n  output  1  legacy INTx assert; tied to 1.
- cfg_interrupt_di  output  8  MSI data; constant MSI_VECTOR.
- irq_source  output  2  snapshot {tx,rx} of the requesters at request launch.
- interrupt_count  output  32  number of completed MSI handshakes; wraps.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values, applied immediately on reset assertion:
  - cfg_interrupt_n=1, cfg_interrupt_assert_n=1, cfg_interrupt_di=MSI_VECTOR.
  - irq_source=0, interrupt_count=0, holdoff counter=0, state=IDLE.
- All outputs are registered. Three states: IDLE, REQ, HOLDOFF.
- IDLE:
  - Launch condition: (rx_send_interrupt | tx_send_interrupt) & interrupts_enabled & cfg_interrupt_msienable.
  - When the launch condition is true at an edge: cfg_interrupt_n<=0, irq_source<={tx_send_interrupt, rx_send_interrupt}, state<=REQ.
  - Latency from the request being sampled to cfg_interrupt_n low is 1 cycle.
- REQ:
  - cfg_interrupt_n is held low until an edge samples cfg_interrupt_rdy_n==0.
  - At that edge: cfg_interrupt_n<=1, interrupt_count<=interrupt_count+1 (mod 2^32), holdoff counter<=holdoff_cycles, state<=HOLDOFF.
  - A request is never withdrawn. Drops of interrupts_enabled, msienable or the source requests while in REQ are ignored until rdy is seen.
  - rdy_n low while in IDLE or HOLDOFF is ignored.
- HOLDOFF:
  - At each edge: if counter==0 then state<=IDLE, else counter<=counter-1.
  - cfg_interrupt_n stays high for exactly holdoff_cycles+2 cycles between handshake completion and the next request, provided a request is already pending.
  - holdoff_cycles=0 gives a 2-cycle gap.
  - Changes to holdoff_cycles during HOLDOFF have no effect until the next handshake.
- Level semantics:
  - Requests still high after HOLDOFF immediately launch a new MSI.
  - Requests that pulse and drop during REQ or HOLDOFF are lost by design; the generators hold their requests while work is outstanding.
- Simultaneous rx and tx requests produce one MSI, with irq_source=2'b11.
- Reset mid-REQ: cfg_interrupt_n returns high immediately; the endpoint transaction is abandoned and the endpoint is reset alongside.
- interrupt_count is 32 bits and wraps from FFFFFFFF to 0.

Test Plan:
- Reset, then rx_send_interrupt=1, enabled=1, msienable=1, holdoff=0: cfg_interrupt_n goes low 1 cycle after the request is sampled. With rdy_n low 3 cycles later, cfg_interrupt_n goes high at that edge, count=1, irq_source=2'b01.
- rx held high, holdoff_cycles=10, rdy_n returned 1 cycle after every request: cfg_interrupt_n high for exactly 12 cycles between requests; count=3 after 3 handshakes.
- rx and tx asserted in the same cycle: exactly one MSI, irq_source=2'b11, count increments by 1.
- interrupts_enabled=0 or msienable=0 with requests high: cfg_interrupt_n stays 1 for 100 cycles. Setting enabled=1 during REQ-less idle starts a request on the next edge. Dropping enabled during REQ keeps cfg_interrupt_n low until rdy_n=0.
- Async reset asserted while in REQ mid-cycle: cfg_interrupt_n=1 and count=0 before the next clock edge. After release with the request high, a new request launches.
- Force count=FFFFFFFF by running handshakes (or preload in the bench), then one more handshake: count=00000000. rdy_n pulsed low in IDLE causes no count change.
